uart_tx_sched: RTL and testbench

//  Transmit scheduler for the SoC UART. Buffers bytes written by the core LSU decode (UART page, word 0)
//  in a small FIFO and sequences the uart transmitter: pops one byte, pulses transmit, waits for the frame
//  to start and finish, then issues the next. Replaces the direct one-shot u_trans/u_tx_byte path so

---
 rtl/uart_tx_sched.sv | 110 +++++++++++
 tb/tb_uart_tx_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: a byte FIFO feeding a strobe/handshake FSM that paces the uart transmitter.
// A strobe that the uart does not acknowledge within START_TO cycles is repeated with the same byte.
module uart_tx_sched #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int START_TO = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  input  logic          tx_is_transmitting,
  output logic          tx_transmit,
  output logic [7:0]    tx_byte,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy
);

  localparam int CW = (START_TO > 2) ? $clog2(START_TO) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   retry, retry_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  // A full FIFO rejects the write even when a pop frees a slot on the same edge.
  assign push  = wr_en & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      retry   <= '0;
      tx_byte <= 8'h00;
    end else begin
      state <= state_nxt;
      retry <= retry_nxt;
      if (pop) tx_byte <= mem[rptr];
    end
  end

  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry;
    pop         = 1'b0;
    tx_transmit = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          pop       = 1'b1;
          retry_nxt = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx_transmit = 1'b1;
        state_nxt   = WAIT_START;
      end
      WAIT_START: begin
        // Retry fires when the incremented count would reach START_TO-1, so strobes are START_TO apart.
        if (tx_is_transmitting) begin
          state_nxt = WAIT_DONE;
        end else if (retry == CW'(START_TO - 2)) begin
          retry_nxt = '0;
          state_nxt = LOAD;
        end else begin
          retry_nxt = retry + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_is_transmitting) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: table-driven FIFO vectors, uart model with scoreboard, hand-written corner cases.
module tb_uart_tx_sched;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int START_TO = 8;
  localparam int FRAME    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          tx_is_transmitting;
  logic          tx_transmit;
  logic [7:0]    tx_byte;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;

  uart_tx_sched #(.DEPTH(DEPTH), .AW(AW), .START_TO(START_TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .tx_is_transmitting(tx_is_transmitting), .tx_transmit(tx_transmit),
    .tx_byte(tx_byte), .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int strobe_cyc[$];
  int strobe_cnt = 0;
  int ignore_cnt = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // uart model + scoreboard; samples on the falling edge, drives tx_is_transmitting there too
  initial begin : uart_model
    int busy_left;
    logic prev_strobe;
    busy_left = 0;
    prev_strobe = 1'b0;
    tx_is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      check("full_vs_count", full, count == (AW+1)'(DEPTH));
      check("empty_vs_count", empty, count == '0);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_is_transmitting = 1'b0;
      end
      if (tx_transmit) begin
        strobe_cnt++;
        strobe_cyc.push_back(cyc);
        check("no_consec_strobe", prev_strobe, 1'b0);
        if (exp_q.size() == 0) begin
          check("strobe_with_empty_scoreboard", 1, 0);
        end else if (ignore_cnt > 0) begin
          check("retry_byte", tx_byte, exp_q[0]);
          ignore_cnt--;
        end else begin
          check("tx_byte_order", tx_byte, exp_q.pop_front());
          tx_is_transmitting = 1'b1;
          busy_left = FRAME;
        end
      end
      prev_strobe = tx_transmit;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && count == 0 && !tx_is_transmitting) break;
      @(negedge clk);
    end
    check("drain_idle", {busy, count}, '0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] dat;
    logic       clr;
    logic [AW:0] e_count;
    logic       e_full;
    logic       e_ovf;
    logic       accepted;
  } vec_t;

  vec_t vecs[DEPTH+5];

  initial begin : main
    int s0;
    for (int i = 0; i < DEPTH; i++)
      vecs[i] = '{1'b1, 8'hC0 + 8'(i), 1'b0, (AW+1)'(i + 1), (i == DEPTH - 1), 1'b0, 1'b1};
    vecs[DEPTH]   = '{1'b1, 8'hEE, 1'b0, (AW+1)'(DEPTH), 1'b1, 1'b1, 1'b0};
    vecs[DEPTH+1] = '{1'b0, 8'h00, 1'b1, (AW+1)'(DEPTH), 1'b1, 1'b0, 1'b0};
    vecs[DEPTH+2] = '{1'b1, 8'hEE, 1'b1, (AW+1)'(DEPTH), 1'b1, 1'b1, 1'b0};
    vecs[DEPTH+3] = '{1'b0, 8'h00, 1'b1, (AW+1)'(DEPTH), 1'b1, 1'b0, 1'b0};
    vecs[DEPTH+4] = '{1'b0, 8'h00, 1'b0, (AW+1)'(DEPTH), 1'b1, 1'b0, 1'b0};

    rst = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_transmit", tx_transmit, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // single byte: strobe in the second cycle after the write edge
    push(8'h41);
    check("t1_no_strobe_yet", tx_transmit, 0);
    @(negedge clk);
    check("t1_strobe", tx_transmit, 1);
    check("t1_byte", tx_byte, 8'h41);
    @(negedge clk);
    check("t1_strobe_single", tx_transmit, 0);
    wait_idle(60);
    check("t1_byte_held", tx_byte, 8'h41);

    // 16 back-to-back writes
    s0 = strobe_cnt;
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    wait_idle(DEPTH * (FRAME + 6) + 50);
    check("t2_strobes", strobe_cnt - s0, DEPTH);
    check("t2_no_overflow", overflow, 0);

    // table: fill with scheduler held, overflow set/clear, set-wins
    enable = 1'b0;
    foreach (vecs[k]) begin
      wr_en = vecs[k].wr;
      wr_data = vecs[k].dat;
      clr_ovf = vecs[k].clr;
      if (vecs[k].accepted) exp_q.push_back(vecs[k].dat);
      @(negedge clk);
      wr_en = 1'b0;
      clr_ovf = 1'b0;
      check($sformatf("t3_count[%0d]", k), count, vecs[k].e_count);
      check($sformatf("t3_full[%0d]", k), full, vecs[k].e_full);
      check($sformatf("t3_ovf[%0d]", k), overflow, vecs[k].e_ovf);
    end
    check("t3_idle_while_disabled", busy, 0);
    enable = 1'b1;
    wait_idle(DEPTH * (FRAME + 6) + 50);

    // uart ignores first strobe: retry after START_TO cycles with same byte
    s0 = strobe_cnt;
    ignore_cnt = 1;
    push(8'h55);
    wait_idle(80);
    check("t4_strobes", strobe_cnt - s0, 2);
    check("t4_gap", strobe_cyc[$] - strobe_cyc[$-1], START_TO);

    // disable mid-frame with 3 queued
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 20 && !tx_is_transmitting; i++) @(negedge clk);
    check("t5_frame_started", tx_is_transmitting, 1);
    enable = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("t5_busy_low", busy, 0);
    check("t5_count", count, 3);
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    check("t5_held_strobes", strobe_cnt - s0, 0);
    check("t5_held_count", count, 3);
    check("t5_byte_held", tx_byte, 8'hA0);
    enable = 1'b1;
    wait_idle(4 * (FRAME + 6) + 50);

    // reset during WAIT_DONE with 5 queued
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    check("t6_in_frame", {busy, tx_is_transmitting}, 2'b11);
    check("t6_count_before", count, 5);
    rst = 1'b1;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_busy", busy, 0);
    check("t6_tx_transmit", tx_transmit, 0);
    check("t6_tx_byte", tx_byte, 8'h00);
    check("t6_overflow", overflow, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    check("t6_no_strobe_after", strobe_cnt - s0, 0);
    check("t6_still_empty", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
